booth_mult16: RTL and testbench



---
 rtl/booth_mult16_pkg.sv | 11 +
 rtl/booth_mult16_rc_adder.sv | 20 ++
 rtl/booth_mult16.sv | 66 ++++++
 tb/tb_booth_mult16.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/booth_mult16_pkg.sv
// mult_pkg: shared types and constants for the Booth multiplier datapath.
package mult_pkg;
  localparam int N = 16;
  localparam int PW = 32;
  localparam int ITER = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {ADD, SUB, HOLD} sel_e;
  function automatic sel_e booth_sel(input logic [1:0] pair);
    return pair == 2'b01 ? ADD : pair == 2'b10 ? SUB : HOLD;
  endfunction
endpackage

// File: rtl/booth_mult16_rc_adder.sv
// rc_adder: W-bit ripple-carry adder with carry-in and carry-out.
module rc_adder
  import mult_pkg::*;
#(
  parameter int W = PW
) (
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         Cin,
  output logic [W-1:0] add,
  output logic         Co
);
  logic [W:0] c;
  assign c[0] = Cin;
  assign Co = c[W];
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign add[i] = inA[i] ^ inB[i] ^ c[i];
    assign c[i+1] = (inA[i] & inB[i]) | (c[i] & (inA[i] ^ inB[i]));
  end
endmodule

// File: rtl/booth_mult16.sv
// booth_mult16: sequential radix-2 Booth signed 16x16 multiplier, one step per clock through rc_adder.
module booth_mult16
  import mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [N-1:0]   inA,
  input  logic signed [N-1:0]   inB,
  output logic                  busy,
  output logic                  done,
  output logic signed [PW-1:0]  mul
);
  localparam int CW = $clog2(ITER);
  state_e state_q, state_d;
  logic [PW-1:0] mcand_q, mcand_d, prod_q, prod_d, mul_q, mul_d, add_b, sum;
  logic [N-1:0] mplr_q, mplr_d;
  logic q1_q, q1_d, add_cin, accept, run, last, unused_co;
  logic [CW-1:0] cnt_q, cnt_d;
  sel_e sel;
  rc_adder #(.W(PW)) u_add (
    .inA(prod_q),
    .inB(add_b),
    .Cin(add_cin),
    .add(sum),
    .Co(unused_co)
  );
  always_comb begin
    sel = booth_sel({mplr_q[0], q1_q});
    add_b = sel == ADD ? mcand_q : sel == SUB ? ~mcand_q : '0;
    add_cin = sel == SUB;
    run = state_q == RUN;
    accept = start && !run;
    last = run && cnt_q == CW'(ITER - 1);
    state_d = accept ? RUN : last ? DONE : run ? RUN : IDLE;
    mcand_d = accept ? {{(PW-N){inA[N-1]}}, inA} : run ? mcand_q << 1 : mcand_q;
    {mplr_d, q1_d} = accept ? {inB, 1'b0} : run ? {mplr_q[N-1], mplr_q} : {mplr_q, q1_q};
    prod_d = accept ? '0 : run ? sum : prod_q;
    cnt_d = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    mul_d = last ? sum : mul_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q <= '0;
      q1_q <= 1'b0;
      prod_q <= '0;
      cnt_q <= '0;
      mul_q <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q <= mplr_d;
      q1_q <= q1_d;
      prod_q <= prod_d;
      cnt_q <= cnt_d;
      mul_q <= mul_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign mul = mul_q;
endmodule

// File: tb/tb_booth_mult16.sv
// tb_booth_mult16: scoreboard bench checking products, latency, busy length and result stability.
module tb_booth_mult16;
  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic signed [15:0] inA, inB;
  logic signed [31:0] mul;
  typedef struct {
    logic [31:0] exp;
    int acc;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, mon_busy = 0;
  logic [31:0] mon_last = '0;

  booth_mult16 dut (
    .clk(clk), .rst(rst), .start(start), .inA(inA), .inB(inB),
    .busy(busy), .done(done), .mul(mul)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic issue(input logic signed [15:0] a, input logic signed [15:0] b);
    int g = 0;
    @(negedge clk);
    while (busy && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("issue_wait_busy", {31'b0, busy}, 32'd0);
    start = 1'b1;
    inA = a;
    inB = b;
    sb.push_back(exp_t'{32'(int'(a) * int'(b)), cyc + 1});
    @(negedge clk);
    start = 1'b0;
    inA = 16'($urandom);
    inB = 16'($urandom);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || sb.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_queue", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every edge, pop on done and check value, latency, busy length; otherwise mul must hold.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        mon_busy = 0;
        mon_last = '0;
      end else begin
        if (busy) mon_busy++;
        if (done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 mul=%h want no done (cycle %0d)", mul, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mul", mul, e.exp);
            chk("latency", 32'(cyc - e.acc), 32'd16);
            chk("busy_len", 32'(mon_busy), 32'd16);
            chk("busy_at_done", {31'b0, busy}, 32'd0);
          end
          mon_busy = 0;
          mon_last = mul;
        end else begin
          chk("mul_stable", mul, mon_last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    inA = '0;
    inB = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_mul", mul, 32'd0);
    rst = 1'b0;
    issue(3, 5);
    wait_idle();
    issue(-7, 6);
    issue(6, -7);
    issue(-32768, -32768);
    issue(32767, -32768);
    issue(0, -1);
    wait_idle();
    issue(100, 3);
    repeat (5) @(negedge clk);
    start = 1'b1;
    inA = 9;
    inB = 9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    // Back-to-back: start held high, new operands placed just before each re-accept.
    for (int i = 0; i < 4; i++) begin
      logic signed [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      start = 1'b1;
      inA = a;
      inB = b;
      sb.push_back(exp_t'{32'(int'(a) * int'(b)), cyc + 1});
      repeat (17) @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    issue(1234, -55);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_mul", mul, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    issue(4, 4);
    wait_idle();
    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 10)) @(negedge clk);
        start = 1'b1;
        inA = 16'($urandom);
        inB = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
